// File: rtl/bit_scan_counter.sv
// bit_scan_counter
//   Serial bit-metric unit. A DATA_W-bit operand and a 2-bit mode are latched
//   on an accepted start. One bit is examined per clock, and the unit reports
//   one of these counts:
//     mode 00 : number of ones
//     mode 01 : number of zeros (the inverted operand is counted as ones)
//     mode 10 : leading zeros, scanned from the MSB
//     mode 11 : trailing zeros, scanned from the LSB
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high; aborts any operation in progress
//   start    request, sampled only while idle
//   mode     metric select, latched with start
//   data_in  operand, latched with start
//   busy     high while scanning and during the done cycle
//   done     one-cycle pulse when result is updated
//   result   final count; holds its value until the next completion
module bit_scan_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  r;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   bits_left;
  logic [1:0]         mode_q;

  logic               finish;
  logic [DATA_W-1:0]  r_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   bits_left_next;

  // Per-mode scan step. Population modes stop as soon as no ones remain in
  // the shift register, so their latency depends on the lowest set bit.
  // Zero-run modes stop on the first one seen or once every bit was consumed.
  always_comb begin
    finish         = 1'b0;
    r_next         = r;
    cnt_next       = cnt;
    bits_left_next = bits_left;
    case (mode_q)
      2'b00, 2'b01: begin
        finish   = (r == '0);
        r_next   = r << 1;
        cnt_next = cnt + CNT_W'(r[DATA_W-1]);
      end
      2'b10: begin
        finish         = r[DATA_W-1] | (bits_left == '0);
        r_next         = r << 1;
        cnt_next       = cnt + CNT_W'(1);
        bits_left_next = bits_left - CNT_W'(1);
      end
      default: begin
        finish         = r[0] | (bits_left == '0);
        r_next         = r >> 1;
        cnt_next       = cnt + CNT_W'(1);
        bits_left_next = bits_left - CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      r         <= '0;
      cnt       <= '0;
      bits_left <= '0;
      mode_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r         <= (mode == 2'b01) ? ~data_in : data_in;
            cnt       <= '0;
            bits_left <= CNT_W'(DATA_W);
            mode_q    <= mode;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (finish) begin
            result <= cnt;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            r         <= r_next;
            cnt       <= cnt_next;
            bits_left <= bits_left_next;
          end
        end
        DONE: begin
          // start is deliberately not looked at here; the earliest new
          // request is taken one cycle later, in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
